// File: rtl/mcu_debug_responder.sv
// MCU-side debug command responder: executes debugger commands against core halt/reset,
// register-file and memory debug ports. Optional halt timeout: define DBG_HALT_TIMEOUT_EN.
module mcu_debug_responder #(
   parameter int MEM_LATENCY  = 2,
   parameter int RESET_CYCLES = 4,
   parameter int HALT_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid,
   input  logic        pause,
   input  logic        resume,
   input  logic        reset,
   input  logic        reg_rd,
   input  logic        reg_wr,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic        mem_be,
   input  logic [31:0] addr,
   input  logic [31:0] d_in,
   output logic        busy,
   output logic [31:0] d_rd,
   output logic        error,
   output logic        paused,
   output logic        cpu_halt_req,
   input  logic        cpu_halted,
   output logic        cpu_reset,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_wdata,
   output logic        rf_we,
   input  logic [31:0] rf_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   output logic        mem_byte,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_HALT_WAIT, S_RESET_PULSE, S_REG_ACC, S_MEM_REQ, S_MEM_WAIT, S_DONE
   } state_t;

   typedef enum logic [2:0] {
      C_NOP, C_REG_RD, C_REG_WR, C_MEM_RD, C_MEM_WR
   } cmd_t;

   localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

   state_t      state_q, state_d;
   cmd_t        cmd_q, cmd_d;
   logic [31:0] addr_q, addr_d;
   logic        be_q, be_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] d_rd_q, d_rd_d;
   logic        error_q, error_d;
   logic        paused_q, paused_d;
   logic        halt_req_q, halt_req_d;
   logic        cpu_reset_q, cpu_reset_d;
   logic [4:0]  rf_addr_q, rf_addr_d;
   logic [31:0] rf_wdata_q, rf_wdata_d;
   logic        rf_we_q, rf_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        mem_we_q, mem_we_d;
   logic        mem_re_q, mem_re_d;
   logic        mem_byte_q, mem_byte_d;

`ifdef DBG_HALT_TIMEOUT_EN
   localparam int TO_W = $clog2(HALT_TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

   assign busy = valid | (state_q != S_IDLE);

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      be_d        = be_q;
      cnt_d       = cnt_q;
      d_rd_d      = d_rd_q;
      error_d     = error_q;
      paused_d    = paused_q;
      halt_req_d  = halt_req_q;
      cpu_reset_d = cpu_reset_q;
      rf_addr_d   = rf_addr_q;
      rf_wdata_d  = rf_wdata_q;
      rf_we_d     = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      mem_byte_d  = mem_byte_q;
`ifdef DBG_HALT_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (valid) begin
               error_d = 1'b0;
               addr_d  = addr;
               be_d    = mem_be;
               cmd_d   = C_NOP;
               // Single-step commands and rejected commands all pass through REG_ACC
               // so every one of them completes with the same three-cycle latency.
               if (pause) begin
                  if (paused_q) begin
                     state_d = S_REG_ACC;
                  end else begin
                     halt_req_d = 1'b1;
                     state_d    = S_HALT_WAIT;
`ifdef DBG_HALT_TIMEOUT_EN
                     to_cnt_d   = '0;
`endif
                  end
               end else if (resume) begin
                  halt_req_d = 1'b0;
                  paused_d   = 1'b0;
                  state_d    = S_REG_ACC;
               end else if (reset) begin
                  cpu_reset_d = 1'b1;
                  cnt_d       = 4'(RESET_CYCLES - 1);
                  state_d     = S_RESET_PULSE;
               end else if (reg_rd || reg_wr) begin
                  state_d = S_REG_ACC;
                  if (!paused_q || (addr >= 32'd32)) begin
                     error_d = 1'b1;
                     d_rd_d  = ERR_DATA;
                  end else begin
                     rf_addr_d  = addr[4:0];
                     cmd_d      = reg_rd ? C_REG_RD : C_REG_WR;
                     if (!reg_rd) begin
                        rf_wdata_d = d_in;
                        rf_we_d    = (addr != 32'd0);
                     end else begin
                        rf_we_d    = 1'b0;
                     end
                  end
               end else if (mem_rd || mem_wr) begin
                  if (!paused_q || (!mem_be && (addr[1:0] != 2'b00))) begin
                     error_d = 1'b1;
                     d_rd_d  = ERR_DATA;
                     state_d = S_REG_ACC;
                  end else begin
                     mem_addr_d  = addr;
                     mem_byte_d  = mem_be;
                     mem_wdata_d = mem_be ? {4{d_in[7:0]}} : d_in;
                     mem_re_d    = mem_rd;
                     mem_we_d    = !mem_rd;
                     cmd_d       = mem_rd ? C_MEM_RD : C_MEM_WR;
                     state_d     = S_MEM_REQ;
                  end
               end else begin
                  state_d = S_REG_ACC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HALT_WAIT: begin
            if (cpu_halted) begin
               paused_d = 1'b1;
               state_d  = S_DONE;
            end
`ifdef DBG_HALT_TIMEOUT_EN
            else if (to_cnt_q == TO_W'(HALT_TIMEOUT - 1)) begin
               halt_req_d = 1'b0;
               error_d    = 1'b1;
               state_d    = S_DONE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
`else
            else begin
               state_d = S_HALT_WAIT;
            end
`endif
         end
         S_RESET_PULSE: begin
            if (cnt_q == 4'd0) begin
               cpu_reset_d = 1'b0;
               state_d     = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_REG_ACC: begin
            if (cmd_q == C_REG_RD) begin
               d_rd_d = (addr_q == 32'd0) ? 32'd0 : rf_rdata;
            end else begin
               d_rd_d = d_rd_q;
            end
            state_d = S_DONE;
         end
         S_MEM_REQ: begin
            cnt_d   = 4'(MEM_LATENCY - 1);
            state_d = S_MEM_WAIT;
         end
         S_MEM_WAIT: begin
            // Read data is valid on the final wait cycle.
            if (cnt_q == 4'd0) begin
               if (cmd_q == C_MEM_RD) begin
                  d_rd_d = be_q ? {24'd0, mem_rdata[7:0]} : mem_rdata;
               end else begin
                  d_rd_d = d_rd_q;
               end
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cmd_q       <= C_NOP;
         addr_q      <= 32'd0;
         be_q        <= 1'b0;
         cnt_q       <= 4'd0;
         d_rd_q      <= 32'd0;
         error_q     <= 1'b0;
         paused_q    <= 1'b0;
         halt_req_q  <= 1'b0;
         cpu_reset_q <= 1'b0;
         rf_addr_q   <= 5'd0;
         rf_wdata_q  <= 32'd0;
         rf_we_q     <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_byte_q  <= 1'b0;
`ifdef DBG_HALT_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         be_q        <= be_d;
         cnt_q       <= cnt_d;
         d_rd_q      <= d_rd_d;
         error_q     <= error_d;
         paused_q    <= paused_d;
         halt_req_q  <= halt_req_d;
         cpu_reset_q <= cpu_reset_d;
         rf_addr_q   <= rf_addr_d;
         rf_wdata_q  <= rf_wdata_d;
         rf_we_q     <= rf_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         mem_byte_q  <= mem_byte_d;
`ifdef DBG_HALT_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end

   assign d_rd         = d_rd_q;
   assign error        = error_q;
   assign paused       = paused_q;
   assign cpu_halt_req = halt_req_q;
   assign cpu_reset    = cpu_reset_q;
   assign rf_addr      = rf_addr_q;
   assign rf_wdata     = rf_wdata_q;
   assign rf_we        = rf_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign mem_we       = mem_we_q;
   assign mem_re       = mem_re_q;
   assign mem_byte     = mem_byte_q;

endmodule

// File: tb/tb_mcu_debug_responder.sv
// Scoreboard bench for mcu_debug_responder: directed commands push expected
// completions; a monitor pops and compares each time busy falls.
module tb_mcu_debug_responder;

   localparam logic [6:0] SEL_PAUSE  = 7'b1000000;
   localparam logic [6:0] SEL_RESUME = 7'b0100000;
   localparam logic [6:0] SEL_RESET  = 7'b0010000;
   localparam logic [6:0] SEL_REG_RD = 7'b0001000;
   localparam logic [6:0] SEL_REG_WR = 7'b0000100;
   localparam logic [6:0] SEL_MEM_RD = 7'b0000010;
   localparam logic [6:0] SEL_MEM_WR = 7'b0000001;
   localparam logic [6:0] SEL_NONE   = 7'b0000000;
   localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

   logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
   logic pause = 1'b0, resume = 1'b0, reset = 1'b0, reg_rd = 1'b0, reg_wr = 1'b0;
   logic mem_rd = 1'b0, mem_wr = 1'b0, mem_be = 1'b0;
   logic [31:0] addr = 32'd0, d_in = 32'd0;
   logic busy, error, paused, cpu_halt_req, cpu_reset, rf_we, mem_we, mem_re, mem_byte;
   logic cpu_halted = 1'b0;
   logic [31:0] d_rd, rf_wdata, rf_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [4:0]  rf_addr;

   logic [31:0] rf  [0:31];
   logic [31:0] mem [0:255];
   logic [31:0] mem_lat_addr = 32'd0;

   typedef struct {
      string       name;
      logic [31:0] d_rd;
      logic        error;
      logic        paused;
      int          lat;
      int          t_issue;
   } exp_t;
   exp_t sb_q[$];

   int vectors = 0, miscompares = 0, cyc = 0;
   int rf_we_cnt = 0, mem_we_cnt = 0, mem_re_cnt = 0;
   int rf_we_run = 0, mem_we_run = 0, mem_re_run = 0, strobe_max = 0;
   int rst_run = 0, rst_last_run = 0;
   logic [31:0] last_mem_wdata = 32'd0;
   logic busy_prev = 1'b0;

   mcu_debug_responder #(.MEM_LATENCY(2), .RESET_CYCLES(4), .HALT_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .pause(pause), .resume(resume), .reset(reset),
      .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_be(mem_be),
      .addr(addr), .d_in(d_in), .busy(busy), .d_rd(d_rd), .error(error), .paused(paused),
      .cpu_halt_req(cpu_halt_req), .cpu_halted(cpu_halted), .cpu_reset(cpu_reset),
      .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rdata(rf_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_byte(mem_byte), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Core-side models: combinational register file, memory with data held from request.
   assign rf_rdata  = rf[rf_addr];
   assign mem_rdata = mem[mem_lat_addr[9:2]];
   always @(posedge clk) begin
      if (rf_we) rf[rf_addr] <= rf_wdata;
      if (mem_re) mem_lat_addr <= mem_addr;
      if (mem_we) begin
         if (mem_byte) mem[mem_addr[9:2]][mem_addr[1:0]*8 +: 8] <= mem_wdata[7:0];
         else          mem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Strobe activity and pulse-width tracking.
   always @(negedge clk) begin
      if (rf_we)  begin rf_we_cnt++;  rf_we_run++;  end else rf_we_run = 0;
      if (mem_we) begin mem_we_cnt++; mem_we_run++; last_mem_wdata = mem_wdata; end else mem_we_run = 0;
      if (mem_re) begin mem_re_cnt++; mem_re_run++; end else mem_re_run = 0;
      if (rf_we_run  > strobe_max) strobe_max = rf_we_run;
      if (mem_we_run > strobe_max) strobe_max = mem_we_run;
      if (mem_re_run > strobe_max) strobe_max = mem_re_run;
      if (cpu_reset) rst_run++;
      else if (rst_run > 0) begin rst_last_run = rst_run; rst_run = 0; end
   end

   // Completion monitor: a falling busy marks the end of a command.
   always @(negedge clk) begin
      if (busy_prev && !busy) begin
         if (sb_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_completion: got busy fall at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.name, ".d_rd"}, d_rd, e.d_rd);
            chk({e.name, ".error"}, {31'd0, error}, {31'd0, e.error});
            chk({e.name, ".paused"}, {31'd0, paused}, {31'd0, e.paused});
            if (e.lat >= 0) chk({e.name, ".latency"}, cyc - e.t_issue, e.lat);
         end
      end
      busy_prev = busy;
   end

   // Caller is positioned #1 after a posedge; returns #1 after the next one.
   task automatic issue(input logic [6:0] sel, input logic be, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] ed, input logic ee,
                        input logic ep, input int lat, input string nm);
      exp_t e;
      {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = sel;
      mem_be = be; addr = a; d_in = d; valid = 1'b1;
      e.name = nm; e.d_rd = ed; e.error = ee; e.paused = ep; e.lat = lat; e.t_issue = cyc;
      sb_q.push_back(e);
      @(posedge clk); #1;
      valid = 1'b0;
      {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = SEL_NONE;
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb_q.size() != 0) begin
         vectors++; miscompares++;
         $display("FAIL %s_timeout: got busy still high after %0d cycles expected completion", nm, n);
         sb_q.delete();
      end
   endtask

   initial begin
      int rfc, mwc, mrc;
      for (int i = 0; i < 32; i++)  rf[i] = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      rf[0] = 32'h0000_0055;
      rf[5] = 32'h5555_AAAA;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy", {31'd0, busy}, 32'd0);
      chk("rst.d_rd", d_rd, 32'd0);
      chk("rst.flags", {27'd0, error, paused, cpu_halt_req, cpu_reset, rf_we}, 32'd0);
      chk("rst.mem_strobes", {30'd0, mem_we, mem_re}, 32'd0);
      chk("rst.mem_addr", mem_addr, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      rfc = rf_we_cnt;
      issue(SEL_REG_RD, 1'b0, 32'd5, 32'd0, DEAD, 1'b1, 1'b0, 3, "reg_rd_unpaused");
      wait_done("reg_rd_unpaused");
      chk("reg_rd_unpaused.rf_we", rf_we_cnt - rfc, 32'd0);

      issue(SEL_PAUSE, 1'b0, 32'd0, 32'd0, DEAD, 1'b0, 1'b1, 7, "pause");
      chk("pause.halt_req_t1", {31'd0, cpu_halt_req}, 32'd1);
      repeat (4) @(posedge clk);
      #1 cpu_halted = 1'b1;
      wait_done("pause");

      rfc = rf_we_cnt;
      issue(SEL_REG_WR, 1'b0, 32'd3, 32'h1234_5678, DEAD, 1'b0, 1'b1, 3, "reg_wr3");
      wait_done("reg_wr3");
      chk("reg_wr3.rf_we", rf_we_cnt - rfc, 32'd1);
      issue(SEL_REG_RD, 1'b0, 32'd3, 32'd0, 32'h1234_5678, 1'b0, 1'b1, 3, "reg_rd3");
      wait_done("reg_rd3");

      mwc = mem_we_cnt;
      issue(SEL_MEM_WR, 1'b0, 32'h100, 32'hCAFE_F00D, 32'h1234_5678, 1'b0, 1'b1, 5, "mem_wr_w");
      wait_done("mem_wr_w");
      chk("mem_wr_w.mem_we", mem_we_cnt - mwc, 32'd1);
      issue(SEL_MEM_RD, 1'b0, 32'h100, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b1, 5, "mem_rd_w");
      wait_done("mem_rd_w");
      mrc = mem_re_cnt;
      issue(SEL_MEM_RD, 1'b0, 32'h102, 32'd0, DEAD, 1'b1, 1'b1, 3, "mem_rd_misaligned");
      wait_done("mem_rd_misaligned");
      chk("mem_rd_misaligned.mem_re", mem_re_cnt - mrc, 32'd0);

      mem[8'h40] = 32'h1234_56A5;
      issue(SEL_MEM_RD, 1'b1, 32'h101, 32'd0, 32'h0000_00A5, 1'b0, 1'b1, 5, "mem_rd_byte");
      wait_done("mem_rd_byte");
      issue(SEL_MEM_WR, 1'b1, 32'h203, 32'h1122_3344, 32'h0000_00A5, 1'b0, 1'b1, 5, "mem_wr_byte");
      wait_done("mem_wr_byte");
      chk("mem_wr_byte.wdata", last_mem_wdata, 32'h4444_4444);
      chk("mem_wr_byte.lane", mem[8'h80], 32'h4400_0000);

      rfc = rf_we_cnt;
      issue(SEL_REG_WR, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'h0000_00A5, 1'b0, 1'b1, 3, "reg_wr0");
      wait_done("reg_wr0");
      chk("reg_wr0.rf_we", rf_we_cnt - rfc, 32'd0);
      issue(SEL_REG_RD, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 3, "reg_rd0");
      wait_done("reg_rd0");
      issue(SEL_REG_RD, 1'b0, 32'd32, 32'd0, DEAD, 1'b1, 1'b1, 3, "reg_rd32");
      wait_done("reg_rd32");
      issue(SEL_REG_RD | SEL_MEM_WR, 1'b0, 32'd5, 32'd0, 32'h5555_AAAA, 1'b0, 1'b1, 3, "prio_reg_rd");
      wait_done("prio_reg_rd");

      issue(SEL_RESET, 1'b0, 32'd0, 32'd0, 32'h5555_AAAA, 1'b0, 1'b1, 6, "reset");
      chk("reset.cpu_reset_t1", {31'd0, cpu_reset}, 32'd1);
      @(posedge clk); #1;
      {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = SEL_RESUME;
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = SEL_NONE;
      wait_done("reset");
      chk("reset.pulse_width", rst_last_run, 32'd4);
      chk("reset.halt_req", {31'd0, cpu_halt_req}, 32'd1);

      issue(SEL_PAUSE, 1'b0, 32'd0, 32'd0, 32'h5555_AAAA, 1'b0, 1'b1, 3, "pause_again");
      wait_done("pause_again");
      issue(SEL_NONE, 1'b0, 32'd0, 32'd0, 32'h5555_AAAA, 1'b0, 1'b1, 3, "noop");
      wait_done("noop");
      issue(SEL_RESUME, 1'b0, 32'd0, 32'd0, 32'h5555_AAAA, 1'b0, 1'b0, 3, "resume");
      wait_done("resume");
      chk("resume.halt_req", {31'd0, cpu_halt_req}, 32'd0);
      issue(SEL_MEM_RD, 1'b0, 32'h100, 32'd0, DEAD, 1'b1, 1'b0, 3, "mem_rd_unpaused");
      wait_done("mem_rd_unpaused");
      chk("strobe.max_width", strobe_max, 32'd1);

`ifdef DBG_HALT_TIMEOUT_EN
      cpu_halted = 1'b0;
      issue(SEL_PAUSE, 1'b0, 32'd0, 32'd0, DEAD, 1'b1, 1'b0, -1, "halt_timeout");
      wait_done("halt_timeout");
      chk("halt_timeout.halt_req", {31'd0, cpu_halt_req}, 32'd0);
      cpu_halted = 1'b1;
`endif

      issue(SEL_PAUSE, 1'b0, 32'd0, 32'd0, DEAD, 1'b0, 1'b1, 3, "pause_fast");
      wait_done("pause_fast");
      issue(SEL_MEM_RD, 1'b0, 32'h100, 32'd0, 32'd0, 1'b0, 1'b0, -1, "abort");
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort.flags", {27'd0, busy, error, paused, cpu_halt_req, cpu_reset}, 32'd0);
      chk("abort.strobes", {29'd0, rf_we, mem_we, mem_re}, 32'd0);
      chk("abort.mem_addr", mem_addr, 32'd0);
      chk("abort.d_rd", d_rd, 32'd0);
      wait_done("abort");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mcu_debug_responder.md
# mcu_debug_responder

MCU-side endpoint of the UART debugger command interface. It accepts the single-cycle `valid` commands issued by `mcu_controller` (pause, resume, reset, reg/mem read/write) and executes them against the CPU core's halt/reset controls, register-file debug port and memory debug port. It returns `busy`, `d_rd` and `error` to the controller per the debugger handshake. It sits between `mcu_controller` and the core, replacing any ad-hoc bench responder.

## Interface
- `MEM_LATENCY`, 2: cycles from memory request to valid `mem_rdata` (1..15).
- `RESET_CYCLES`, 4: width of the `cpu_reset` pulse in cycles (1..15).
- `HALT_TIMEOUT`, 1024: cycles to wait for `cpu_halted` (used only with `DBG_HALT_TIMEOUT_EN`).
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid` in 1: command strobe, one cycle.
- `pause`, `resume`, `reset`, `reg_rd`, `reg_wr`, `mem_rd`, `mem_wr` in 1 each: command select, sampled with `valid`.
- `mem_be` in 1: byte access (1) vs word access (0) for mem commands.
- `addr` in 32: register index (0..31) or byte address.
- `d_in` in 32: write data.
- `busy` out 1: command in progress.
- `d_rd` out 32: read data, valid while `busy`=0.
- `error` out 1: last command failed.
- `paused` out 1: core is held by the debugger.
- `cpu_halt_req` out 1: request the core to halt.
- `cpu_halted` in 1: core has drained and stopped.
- `cpu_reset` out 1: core reset pulse.
- `rf_addr` out 5, `rf_wdata` out 32, `rf_we` out 1, `rf_rdata` in 32: register-file debug port; `rf_rdata` is combinational.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_we` out 1, `mem_re` out 1, `mem_byte` out 1, `mem_rdata` in 32: memory debug port.

## Operation
- FSM states: IDLE, HALT_WAIT, RESET_PULSE, REG_ACC, MEM_REQ, MEM_WAIT, DONE.
- `busy` = `valid` | (state != IDLE). This is combinational, so `busy` is high in the `valid` cycle.
- `valid` is accepted only in IDLE. A `valid` arriving while busy is ignored.
- Command priority when several selects are high: pause > resume > reset > reg_rd > reg_wr > mem_rd > mem_wr. With no select high, the command is a no-op that goes to DONE.
- Every accepted command clears `error` and latches `addr`, `d_in` and `mem_be`.
- pause:
  - Sets `cpu_halt_req` and enters HALT_WAIT.
  - On `cpu_halted`=1: sets `paused` and goes to DONE.
  - If already paused: goes straight to DONE.
- resume: clears `cpu_halt_req` and `paused`, then DONE.
- reset:
  - Drives `cpu_reset`=1 for exactly RESET_CYCLES cycles (RESET_PULSE), then DONE.
  - `paused` and `cpu_halt_req` are unchanged.
- reg_rd / reg_wr:
  - Require `paused`=1 and `addr`<32. Otherwise no port activity, `error`=1, `d_rd`=32'hDEAD_BEEF, DONE.
  - REG_ACC lasts one cycle with `rf_addr`=addr[4:0].
  - Read: `d_rd`=`rf_rdata`, or 0 when addr==0.
  - Write: `rf_we`=1 with `rf_wdata`=d_in; suppressed when addr==0.
- mem_rd / mem_wr:
  - Require `paused`=1, and addr[1:0]==0 when `mem_be`=0. Otherwise: error as above.
  - MEM_REQ lasts one cycle: `mem_re` or `mem_we` = 1, `mem_addr`=addr, `mem_byte`=mem_be.
  - `mem_wdata` = d_in for word access, {4{d_in[7:0]}} for byte access.
  - MEM_WAIT counts MEM_LATENCY cycles. Read then captures `mem_rdata` (zero-extended [7:0] if byte).
  - Write also waits MEM_LATENCY cycles.
- DONE lasts one cycle, then IDLE.
- `d_rd` is held until the next read or error. Non-read commands leave `d_rd` unchanged.

## Timing
- Reset values:
  - State IDLE; `busy`=0 once `valid`=0.
  - `d_rd`=0, `error`=0, `paused`=0, `cpu_halt_req`=0, `cpu_reset`=0.
  - `rf_we`=0, `mem_we`=0, `mem_re`=0; all address/data outputs 0.
- `rst_n` low mid-command aborts immediately to reset values. Any in-flight memory strobe drops asynchronously.
- Latency with `valid` at cycle T (`busy` first low at):
  - reg op, resume, no-op, or error: T+3.
  - pause when already paused: T+3.
  - mem op: T+3+MEM_LATENCY.
  - reset: T+2+RESET_CYCLES.
  - pause: T+2+(cycles until `cpu_halted`)+1.
- `cpu_halt_req` rises at T+1. `cpu_reset` is high for cycles T+1..T+RESET_CYCLES.
- All strobes (`rf_we`, `mem_we`, `mem_re`) are exactly one cycle wide.

## Configuration
- `DBG_HALT_TIMEOUT_EN` defined:
  - HALT_WAIT counts cycles; reaching HALT_TIMEOUT without `cpu_halted` ends the wait.
  - On timeout: clears `cpu_halt_req`, leaves `paused`=0, sets `error`=1, DONE.
- Undefined: HALT_WAIT waits indefinitely, no counter is instantiated, and HALT_TIMEOUT is unused.

## Test plan
- pause with `cpu_halted` rising 5 cycles later; then reg_wr addr=3 d_in=32'h1234_5678; then reg_rd addr=3 → `paused`=1; `rf_we` pulse; `d_rd`=32'h1234_5678; `error`=0.
- reg_rd addr=5 while not paused → no `rf_*` activity, `error`=1, `d_rd`=32'hDEAD_BEEF, `busy` low at T+3.
- Paused; mem_wr word addr=0x100 d_in=32'hCAFE_F00D, then mem_rd word addr=0x100 with MEM_LATENCY=2 → `d_rd`=32'hCAFE_F00D, `busy` low at T+5. Then mem_rd word addr=0x102 → `error`=1.
- Paused; mem_rd `mem_be`=1 addr=0x101 with `mem_rdata`=32'h0000_00A5 → `d_rd`=32'h0000_00A5. Then reg_wr addr=0 → `rf_we` never asserted.
- reset (RESET_CYCLES=4) while paused → `cpu_reset` high exactly 4 cycles, `paused` stays 1. A second `valid` while busy is ignored.
- `DBG_HALT_TIMEOUT_EN`, HALT_TIMEOUT=16, `cpu_halted` held 0 → `error`=1, `paused`=0, `cpu_halt_req`=0 after timeout. Separately, `rst_n` asserted during MEM_WAIT → all outputs at reset values.
